// File: rtl/hash_table_pkg.sv
// Shared hash table command/result types plus the
// arbiter state encoding and round-robin pick helper.
package hash_table;

   localparam int HT_KEY_W = 16;
   localparam int HT_VAL_W = 32;

   typedef enum logic [1:0] {
      OP_SEARCH = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2,
      OP_INIT   = 2'd3
   } ht_opcode_t;

   typedef enum logic [3:0] {
      RC_FOUND          = 4'd0,
      RC_NOT_FOUND      = 4'd1,
      RC_INSERT_SUCCESS = 4'd2,
      RC_DUPLICATE      = 4'd3,
      RC_TABLE_FULL     = 4'd4,
      RC_DELETE_SUCCESS = 4'd5,
      INIT_SUCCESS      = 4'd6
   } ht_rcode_t;

   typedef struct packed {
      ht_opcode_t          opcode;
      logic [HT_KEY_W-1:0] key;
      logic [HT_VAL_W-1:0] value;
   } ht_command_t;

   typedef struct packed {
      ht_opcode_t          opcode;
      ht_rcode_t           rcode;
      logic [HT_KEY_W-1:0] key;
      logic [HT_VAL_W-1:0] value;
      logic [HT_VAL_W-1:0] prev_value;
      logic [15:0]         bucket;
      logic [7:0]          probes;
      logic [15:0]         free_cnt;
      logic [11:0]         ptr;
   } ht_result_t;

   localparam int HT_CMD_W = $bits(ht_command_t);
   localparam int HT_RES_W = $bits(ht_result_t);

   typedef enum logic [1:0] {
      ARB,
      DRAIN,
      INIT_ISSUE,
      INIT_WAIT
   } ht_arb_state_t;

   localparam int RR_MAX  = 8;
   localparam int RR_ID_W = 3;

   typedef struct packed {
      logic               found;
      logic [RR_ID_W-1:0] id;
   } rr_pick_t;

   // First set bit of valid[num-1:0] scanning upward from ptr, wrapping.
   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX-1:0]  valid,
      input logic [RR_ID_W-1:0] ptr,
      input int                 num
   );
      rr_pick_t r;
      int       idx;
      r = '0;
      for (int i = 0; i < RR_MAX; i++) begin
         idx = int'(ptr) + i;
         if (idx >= num) idx = idx - num;
         if (!r.found && i < num && valid[RR_ID_W'(idx)]) begin
            r.found = 1'b1;
            r.id    = RR_ID_W'(idx);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ht_tag_fifo.sv
// In-order tag FIFO with first-word-fall-through head.
// Pointers carry a wrap bit to tell full from empty.
module ht_tag_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign data_o  = mem[rd_q[AW-1:0]];

   // Pointer advance; reset empties the queue.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   // Storage write; contents are don't-care while empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/ht_cmd_arbiter.sv
// Round-robin command arbiter in front of one hash table,
// with in-order result steering and serialised OP_INIT.
module ht_cmd_arbiter
   import hash_table::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 16,
   parameter int REQ_ID_WIDTH    = $clog2(NUM_REQ)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REQ*HT_CMD_W-1:0]  req_cmd_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic [HT_CMD_W-1:0]          ht_cmd_o,
   output logic                         ht_cmd_valid_o,
   input  logic                         ht_cmd_ready_i,
   input  logic [HT_RES_W-1:0]          ht_res_i,
   input  logic                         ht_res_valid_i,
   output logic                         ht_res_ready_o,
   output logic [HT_RES_W-1:0]          res_o,
   output logic [NUM_REQ-1:0]           res_valid_o,
   input  logic [NUM_REQ-1:0]           res_ready_i,
   output logic                         orphan_err_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   ht_arb_state_t           state_q;
   ht_arb_state_t           state_d;
   logic [REQ_ID_WIDTH-1:0] rr_q;
   logic [REQ_ID_WIDTH-1:0] init_id_q;
   logic [REQ_ID_WIDTH-1:0] init_id_d;
   logic [CNT_W-1:0]        outstanding_q;
   logic [HT_CMD_W-1:0]     cmd_q;
   logic                    cmd_valid_q;
   logic                    orphan_q;

   rr_pick_t                pick;
   logic [REQ_ID_WIDTH-1:0] win_id;
   logic [REQ_ID_WIDTH-1:0] grant_id;
   ht_command_t             win_cmd;
   logic [HT_CMD_W-1:0]     grant_cmd;
   logic                    slot_free;
   logic                    can_grant;
   logic                    grant;
   logic                    tag_full;
   logic                    tag_empty;
   logic [REQ_ID_WIDTH-1:0] tag_head;
   logic                    res_hs;

   assign pick = rr_pick(RR_MAX'(req_valid_i),
                         RR_ID_W'(rr_q), NUM_REQ);
   assign win_id  = REQ_ID_WIDTH'(pick.id);
   assign win_cmd = ht_command_t'(
      req_cmd_i[win_id*HT_CMD_W +: HT_CMD_W]);
   assign grant_cmd =
      req_cmd_i[grant_id*HT_CMD_W +: HT_CMD_W];

   assign slot_free = !cmd_valid_q || ht_cmd_ready_i;
   assign can_grant = slot_free && !tag_full;

   // An empty tag FIFO means the result is an orphan: swallow it.
   assign ht_res_ready_o = tag_empty ? ht_res_valid_i
                                     : res_ready_i[tag_head];
   assign res_hs  = ht_res_valid_i && ht_res_ready_o && !tag_empty;
   assign res_o   = ht_res_i;

   assign ht_cmd_o       = cmd_q;
   assign ht_cmd_valid_o = cmd_valid_q;
   assign orphan_err_o   = orphan_q;

   ht_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (REQ_ID_WIDTH)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (grant),
      .data_i  (grant_id),
      .pop_i   (res_hs),
      .data_o  (tag_head),
      .full_o  (tag_full),
      .empty_o (tag_empty)
   );

   // Next state and grant decision; INIT is held back until drained.
   always_comb begin
      state_d   = state_q;
      init_id_d = init_id_q;
      grant     = 1'b0;
      grant_id  = win_id;
      unique case (state_q)
         ARB: begin
            if (can_grant && pick.found) begin
               if (win_cmd.opcode == OP_INIT) begin
                  init_id_d = win_id;
                  state_d   = DRAIN;
               end else begin
                  grant = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (outstanding_q == '0 && !cmd_valid_q)
               state_d = INIT_ISSUE;
         end
         INIT_ISSUE: begin
            grant_id = init_id_q;
            if (!req_valid_i[init_id_q]) begin
               state_d = ARB;
            end else if (can_grant) begin
               grant   = 1'b1;
               state_d = INIT_WAIT;
            end
         end
         INIT_WAIT: begin
            if (res_hs) state_d = ARB;
         end
         default: state_d = ARB;
      endcase
   end

   // One-hot ready for the granted requester only.
   always_comb begin
      req_ready_o = '0;
      if (grant) req_ready_o[grant_id] = 1'b1;
   end

   // Result valid is steered to the owner at the tag head.
   always_comb begin
      res_valid_o = '0;
      if (ht_res_valid_i && !tag_empty)
         res_valid_o[tag_head] = 1'b1;
   end

   // FSM, latched INIT owner and round-robin pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ARB;
         init_id_q <= '0;
         rr_q      <= '0;
      end else begin
         state_q   <= state_d;
         init_id_q <= init_id_d;
         if (grant) begin
            if (grant_id == REQ_ID_WIDTH'(NUM_REQ - 1))
               rr_q <= '0;
            else
               rr_q <= grant_id + REQ_ID_WIDTH'(1);
         end
      end
   end

   // Registered output slot toward the hash table.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
      end else if (grant) begin
         cmd_q       <= grant_cmd;
         cmd_valid_q <= 1'b1;
      end else if (ht_cmd_ready_i) begin
         cmd_valid_q <= 1'b0;
      end
   end

   // In-flight count and sticky orphan flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding_q <= '0;
         orphan_q      <= 1'b0;
      end else begin
         if (grant && !res_hs)
            outstanding_q <= outstanding_q + CNT_W'(1);
         else if (!grant && res_hs)
            outstanding_q <= outstanding_q - CNT_W'(1);
         if (ht_res_valid_i && tag_empty)
            orphan_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Directed and random checks of ht_cmd_arbiter against a
// queue-based reference of grants, slot and result order.
module tb_ht_cmd_arbiter;
   import hash_table::*;

   localparam int N = 4;
   localparam int D = 16;
   localparam int W = HT_CMD_W;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N*W-1:0]       req_cmd;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [W-1:0]         ht_cmd;
   logic                 ht_cmd_valid;
   logic                 ht_cmd_ready;
   logic [HT_RES_W-1:0]  ht_res;
   logic                 ht_res_valid;
   logic                 ht_res_ready;
   logic [HT_RES_W-1:0]  res;
   logic [N-1:0]         res_valid;
   logic [N-1:0]         res_ready;
   logic                 orphan;

   int errors = 0;
   int checks = 0;

   int            m_rr;
   bit            m_sv;
   logic [W-1:0]  m_sc;
   int            m_tags[$];
   logic [W-1:0]  ht_q[$];
   int            n_grants;

   always #5 clk = ~clk;

   ht_cmd_arbiter #(
      .NUM_REQ         (N),
      .MAX_OUTSTANDING (D)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_cmd_i      (req_cmd),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .ht_cmd_o       (ht_cmd),
      .ht_cmd_valid_o (ht_cmd_valid),
      .ht_cmd_ready_i (ht_cmd_ready),
      .ht_res_i       (ht_res),
      .ht_res_valid_i (ht_res_valid),
      .ht_res_ready_o (ht_res_ready),
      .res_o          (res),
      .res_valid_o    (res_valid),
      .res_ready_i    (res_ready),
      .orphan_err_o   (orphan)
   );

   task automatic check(input string tag,
                        input logic [255:0] obs,
                        input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mk_cmd(input ht_opcode_t op,
                                           input logic [15:0] key,
                                           input logic [31:0] val);
      ht_command_t c;
      c.opcode = op;
      c.key    = key;
      c.value  = val;
      return c;
   endfunction

   function automatic logic [HT_RES_W-1:0] mk_res(input logic [W-1:0] cw);
      ht_command_t c;
      ht_result_t  r;
      c = cw;
      r = '0;
      r.opcode = c.opcode;
      r.rcode  = (c.opcode == OP_INIT) ? INIT_SUCCESS : RC_FOUND;
      r.key    = c.key;
      r.value  = c.value ^ 32'h5a5a_a5a5;
      r.ptr    = c.key[11:0];
      return r;
   endfunction

   task automatic set_cmd(input int i, input logic [W-1:0] c);
      req_cmd[i*W +: W] = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic advance();
      tick();
      if (ht_q.size() > 0) ht_res = mk_res(ht_q[0]);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      req_valid    = '0;
      req_cmd      = '0;
      ht_cmd_ready = 1'b0;
      ht_res_valid = 1'b0;
      ht_res       = '0;
      res_ready    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      m_rr = 0;
      m_sv = 1'b0;
      m_sc = '0;
      m_tags.delete();
      ht_q.delete();
      n_grants = 0;
   endtask

   // Check this cycle against the reference, then step the reference.
   task automatic sample();
      int         w;
      bit         can;
      bit         pop;
      logic [N-1:0] er;
      logic       hrr;
      @(negedge clk);
      w   = -1;
      can = (!m_sv || ht_cmd_ready) && (m_tags.size() < D);
      for (int i = 0; i < N; i++) begin
         int j;
         j = (m_rr + i) % N;
         if (w < 0 && req_valid[j]) w = j;
      end
      if (!can) w = -1;
      check("req_ready", req_ready, (w >= 0) ? (1 << w) : 0);
      check("cmd_valid", ht_cmd_valid, m_sv);
      if (m_sv) check("cmd", ht_cmd, m_sc);
      er = '0;
      if (ht_res_valid && m_tags.size() > 0) er[m_tags[0]] = 1'b1;
      check("res_valid", res_valid, er);
      hrr = (m_tags.size() == 0) ? ht_res_valid : res_ready[m_tags[0]];
      check("ht_res_ready", ht_res_ready, hrr);
      check("res_pass", res, ht_res);
      pop = ht_res_valid && m_tags.size() > 0 && res_ready[m_tags[0]];
      if (pop) begin
         void'(m_tags.pop_front());
         if (ht_q.size() > 0) void'(ht_q.pop_front());
      end
      if (m_sv && ht_cmd_ready) ht_q.push_back(m_sc);
      if (w >= 0) begin
         m_tags.push_back(w);
         m_sc = req_cmd[w*W +: W];
         m_sv = 1'b1;
         m_rr = (w + 1) % N;
         n_grants++;
      end else if (ht_cmd_ready) begin
         m_sv = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      ht_command_t  c;
      ht_result_t   r;
      logic [HT_RES_W-1:0] keep;
      int           exp_ord[6];
      bit           got;

      exp_ord = '{0, 1, 2, 3, 0, 1};

      // reset state
      do_reset();
      @(negedge clk);
      check("rst_cmd_valid", ht_cmd_valid, 1'b0);
      check("rst_req_ready", req_ready, 4'b0000);
      check("rst_res_valid", res_valid, 4'b0000);
      check("rst_ht_res_ready", ht_res_ready, 1'b0);
      check("rst_orphan", orphan, 1'b0);
      tick();

      // single requester, latency 1, result 3 cycles later
      ht_cmd_ready = 1'b1;
      res_ready    = '1;
      repeat (2) begin sample(); advance(); end
      req_valid = 4'b0001;
      set_cmd(0, mk_cmd(OP_SEARCH, 16'h0011, 32'h0));
      sample();
      check("t1_grant", req_ready, 4'b0001);
      advance();
      req_valid = '0;
      sample();
      c = ht_cmd;
      check("t1_cmd_valid", ht_cmd_valid, 1'b1);
      check("t1_key", c.key, 16'h0011);
      advance();
      repeat (2) begin sample(); advance(); end
      ht_res_valid = 1'b1;
      sample();
      check("t1_res_valid", res_valid, 4'b0001);
      check("t1_orphan", orphan, 1'b0);
      advance();
      ht_res_valid = 1'b0;
      sample(); advance();

      // all requesters busy: round-robin order
      do_reset();
      ht_cmd_ready = 1'b1;
      res_ready    = '1;
      req_valid    = '1;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < N; j++)
            set_cmd(j, mk_cmd(OP_INSERT, 16'(i*4 + j), 32'(j)));
         sample();
         check("t2_grant", req_ready, 1 << exp_ord[i]);
         advance();
      end
      req_valid = '0;
      repeat (2) begin sample(); advance(); end
      ht_res_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sample();
         check("t2_res", res_valid, 1 << exp_ord[i]);
         advance();
      end
      ht_res_valid = 1'b0;
      sample(); advance();

      // tag FIFO full with results withheld
      do_reset();
      ht_cmd_ready = 1'b1;
      res_ready    = '1;
      req_valid    = '1;
      for (int j = 0; j < N; j++)
         set_cmd(j, mk_cmd(OP_SEARCH, 16'(16'h100 + j), 32'h0));
      repeat (20) begin sample(); advance(); end
      check("t3_accepted", n_grants, 16);
      ht_res_valid = 1'b1;
      sample();
      check("t3_full_stall", req_ready, 4'b0000);
      advance();
      ht_res_valid = 1'b0;
      sample();
      check("t3_refill", req_ready, 4'b0001);
      advance();
      req_valid = '0;

      // result backpressure holds the head tag
      do_reset();
      ht_cmd_ready = 1'b1;
      res_ready    = '1;
      req_valid    = 4'b0010;
      set_cmd(1, mk_cmd(OP_SEARCH, 16'h0051, 32'h1));
      sample(); advance();
      set_cmd(1, mk_cmd(OP_SEARCH, 16'h0052, 32'h2));
      sample(); advance();
      req_valid = '0;
      repeat (2) begin sample(); advance(); end
      ht_res_valid = 1'b1;
      res_ready    = 4'b1101;
      keep         = ht_res;
      repeat (3) begin
         sample();
         check("t5_hold_ready", ht_res_ready, 1'b0);
         check("t5_hold_valid", res_valid, 4'b0010);
         check("t5_hold_data", res, keep);
         advance();
      end
      res_ready = '1;
      sample();
      check("t5_release", ht_res_ready, 1'b1);
      advance();
      sample();
      r = res;
      check("t5_second_valid", res_valid, 4'b0010);
      check("t5_second_key", r.key, 16'h0052);
      advance();
      ht_res_valid = 1'b0;
      sample();
      check("t5_drained", res_valid, 4'b0000);
      advance();

      // OP_INIT drains, issues alone, and blocks until its result
      do_reset();
      ht_cmd_ready = 1'b1;
      res_ready    = '1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 4'b0010;
         set_cmd(1, mk_cmd(OP_INSERT, 16'(i + 1), 32'(i)));
         @(negedge clk);
         check("t4_insert", req_ready, 4'b0010);
         tick();
      end
      req_valid = 4'b0111;
      set_cmd(0, mk_cmd(OP_SEARCH, 16'h00a0, 32'h0));
      set_cmd(1, mk_cmd(OP_SEARCH, 16'h00a1, 32'h0));
      set_cmd(2, mk_cmd(OP_INIT, 16'h0, 32'h0));
      repeat (6) begin
         @(negedge clk);
         check("t4_drain_stall", req_ready, 4'b0000);
         tick();
      end
      @(negedge clk);
      check("t4_slot_empty", ht_cmd_valid, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         ht_res = mk_res(mk_cmd(OP_INSERT, 16'(i + 1), 32'(i)));
         ht_res_valid = 1'b1;
         @(negedge clk);
         check("t4_ins_res", res_valid, 4'b0010);
         check("t4_res_stall", req_ready, 4'b0000);
         tick();
      end
      ht_res_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            got = 1'b1;
            check("t4_init_grant", req_ready, 4'b0100);
         end
         tick();
      end
      check("t4_init_seen", got, 1'b1);
      req_valid = 4'b0011;
      @(negedge clk);
      c = ht_cmd;
      check("t4_init_valid", ht_cmd_valid, 1'b1);
      check("t4_init_op", c.opcode, OP_INIT);
      check("t4_init_alone", req_ready, 4'b0000);
      tick();
      repeat (4) begin
         @(negedge clk);
         check("t4_wait_stall", req_ready, 4'b0000);
         tick();
      end
      ht_res       = mk_res(mk_cmd(OP_INIT, 16'h0, 32'h0));
      ht_res_valid = 1'b1;
      res_ready    = 4'b1011;
      repeat (2) begin
         @(negedge clk);
         check("t4_ires_valid", res_valid, 4'b0100);
         check("t4_ires_hold", ht_res_ready, 1'b0);
         check("t4_ires_stall", req_ready, 4'b0000);
         tick();
      end
      res_ready = '1;
      @(negedge clk);
      r = res;
      check("t4_ires_take", ht_res_ready, 1'b1);
      check("t4_ires_code", r.rcode, INIT_SUCCESS);
      check("t4_ires_stall2", req_ready, 4'b0000);
      tick();
      ht_res_valid = 1'b0;
      @(negedge clk);
      check("t4_resume", req_ready, 4'b0001);
      tick();
      req_valid = '0;

      // random traffic against the reference
      do_reset();
      for (int k = 0; k < 400; k++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++)
            set_cmd(i, mk_cmd(ht_opcode_t'($urandom_range(0, 2)),
                              16'($urandom), $urandom));
         ht_cmd_ready = ($urandom_range(0, 3) != 0);
         res_ready    = N'($urandom);
         ht_res_valid = (ht_q.size() > 0) && ($urandom_range(0, 1) == 1);
         sample();
         advance();
      end

      // reset mid-traffic, then an orphan result
      do_reset();
      ht_res       = mk_res(mk_cmd(OP_SEARCH, 16'hbeef, 32'h1));
      ht_res_valid = 1'b1;
      @(negedge clk);
      check("t6_orphan_ready", ht_res_ready, 1'b1);
      check("t6_orphan_nosteer", res_valid, 4'b0000);
      check("t6_orphan_pre", orphan, 1'b0);
      tick();
      ht_res_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("t6_orphan_sticky", orphan, 1'b1);
         tick();
      end
      do_reset();
      @(negedge clk);
      check("t6_orphan_clear", orphan, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
